// File: rtl/word_serializer_pkg.sv
// Shared types and helpers for the word serializer.
package word_serializer_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StSend
  } state_e;

  // Lane index width; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned num);
    return (num > 1) ? $clog2(num) : 1;
  endfunction

endpackage

// File: rtl/lowest_set_lane.sv
// Priority encoder: lowest set lane of a mask, plus whether any other lane is set above it.
module lowest_set_lane #(
  parameter int unsigned NUM   = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [NUM-1:0]   mask_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o,
  output logic             more_o
);

  // Ascending scan: the first hit is the lowest lane, so any later hit lies above it.
  always_comb begin
    idx_o  = '0;
    any_o  = 1'b0;
    more_o = 1'b0;
    for (int unsigned i = 0; i < NUM; i++) begin
      if (mask_i[i]) begin
        if (any_o) begin
          more_o = 1'b1;
        end else begin
          any_o = 1'b1;
          idx_o = IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/word_serializer.sv
// Parallel-to-serial converter: emits the valid lanes of a held group one word per clock,
// lowest lane first, with out_ready backpressure and back-to-back group handover.
module word_serializer
  import word_serializer_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NUM   = 4,
  localparam int unsigned IDX_W = idx_width(NUM)
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [NUM-1:0][WIDTH-1:0] data_in,
  input  logic [NUM-1:0]            in_valid,
  output logic                      in_ready,
  output logic [WIDTH-1:0]          data_out,
  output logic [IDX_W-1:0]          out_idx,
  output logic                      out_valid,
  output logic                      out_last,
  input  logic                      out_ready
);

  state_e                    state_q, state_d;
  logic [NUM-1:0]            mask_q, mask_d;
  logic [NUM-1:0][WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0]          out_data_q, out_data_d;
  logic [IDX_W-1:0]          out_idx_q, out_idx_d;
  logic                      out_valid_q, out_valid_d;
  logic                      out_last_q, out_last_d;

  logic                      load;
  logic                      beat;
  logic                      present;
  logic [NUM-1:0]            enc_mask;
  logic [IDX_W-1:0]          enc_idx;
  logic                      enc_any;
  logic                      enc_more;
  logic [NUM-1:0]            lane_bit;
  logic [NUM-1:0][WIDTH-1:0] src_data;

  assign in_ready = !rst_in && ((state_q == StIdle) || (out_valid_q && out_ready && out_last_q));
  assign load     = in_ready && (in_valid != '0);
  assign beat     = out_valid_q && out_ready;

  // The held mask already excludes the lane on data_out, so one encoder serves both the
  // first lane of a new group and the next lane of the current one.
  assign enc_mask = load ? in_valid : mask_q;
  assign src_data = load ? data_in : data_q;
  assign lane_bit = NUM'(1) << enc_idx;

  lowest_set_lane #(
    .NUM   (NUM),
    .IDX_W (IDX_W)
  ) u_lowest_set_lane (
    .mask_i (enc_mask),
    .idx_o  (enc_idx),
    .any_o  (enc_any),
    .more_o (enc_more)
  );

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    data_d      = data_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    present     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (load) begin
          state_d = StSend;
          present = 1'b1;
        end
      end
      StSend: begin
        if (beat) begin
          if (!out_last_q || load) begin
            present = 1'b1;
          end else begin
            state_d     = StIdle;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
          end
        end
      end
    endcase

    if (present && enc_any) begin
      out_data_d  = src_data[enc_idx];
      out_idx_d   = enc_idx;
      out_valid_d = 1'b1;
      out_last_d  = !enc_more;
      mask_d      = enc_mask & ~lane_bit;
      if (load) begin
        data_d = data_in;
      end
    end else if (present) begin
      // Unreachable with a consistent held mask; fall back to idle rather than emit garbage.
      state_d     = StIdle;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= StIdle;
      mask_q      <= '0;
      data_q      <= '0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      data_q      <= data_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign data_out  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_word_serializer.sv
// Self-checking bench for word_serializer: directed vector table, hand sequences,
// and randomized traffic against a queue-based reference model.
module tb_word_serializer;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned NUM   = 4;

  logic                      clk_in = 1'b0;
  logic                      rst_in;
  logic [NUM-1:0][WIDTH-1:0] data_in;
  logic [NUM-1:0]            in_valid;
  logic                      in_ready;
  logic [WIDTH-1:0]          data_out;
  logic [1:0]                out_idx;
  logic                      out_valid;
  logic                      out_last;
  logic                      out_ready;

  word_serializer #(
    .WIDTH (WIDTH),
    .NUM   (NUM)
  ) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .data_in   (data_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_out  (data_out),
    .out_idx   (out_idx),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [7:0] d;
    int         idx;
    logic       last;
  } beat_t;

  typedef struct {
    logic        rst;
    logic [31:0] d;
    logic [3:0]  v;
    logic        r;
    logic        irdy;
    logic        ov;
    logic        cd;
    logic [7:0]  od;
    logic [1:0]  oi;
    logic        ol;
  } vec_t;

  beat_t      exp_q[$];
  vec_t       vecs[$];
  logic [7:0] log_d[$];
  int         log_i[$];
  int         log_c[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  logic       exp_irdy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input logic rst, input logic [31:0] d, input logic [3:0] v,
                              input logic r, input logic irdy, input logic ov, input logic cd,
                              input logic [7:0] od, input logic [1:0] oi, input logic ol);
    vec_t t;
    t.rst = rst; t.d = d; t.v = v; t.r = r; t.irdy = irdy;
    t.ov = ov; t.cd = cd; t.od = od; t.oi = oi; t.ol = ol;
    return t;
  endfunction

  // Drive one cycle's inputs (just after a rising edge) and move to the falling edge.
  task automatic apply(input logic rst, input logic [31:0] d, input logic [3:0] v,
                       input logic r);
    rst_in    = rst;
    data_in   = d;
    in_valid  = v;
    out_ready = r;
    #4;
    exp_irdy = !rst && (exp_q.size() == 0 || (exp_q.size() == 1 && r));
    if (!rst_in && out_valid === 1'b1 && out_ready) begin
      log_d.push_back(data_out);
      log_i.push_back(int'(out_idx));
      log_c.push_back(cyc);
    end
  endtask

  task automatic check_model();
    chk("in_ready", 32'(in_ready), 32'(exp_irdy));
    chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      chk("data_out", 32'(data_out), 32'(exp_q[0].d));
      chk("out_idx", 32'(out_idx), 32'(exp_q[0].idx));
      chk("out_last", 32'(out_last), 32'(exp_q[0].last));
    end
  endtask

  // Reference model: the queue holds every word still owed, head = word on data_out.
  task automatic advance();
    @(posedge clk_in);
    if (rst_in) begin
      exp_q.delete();
    end else begin
      if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
      if (exp_irdy && in_valid != 0) begin
        for (int i = 0; i < int'(NUM); i++) begin
          if (in_valid[i]) begin
            beat_t b;
            b.d    = data_in[i];
            b.idx  = i;
            b.last = ((int'(in_valid) >> (i + 1)) == 0);
            exp_q.push_back(b);
          end
        end
      end
    end
    cyc++;
    #1;
  endtask

  initial begin
    rst_in    = 1'b1;
    data_in   = '0;
    in_valid  = '0;
    out_ready = 1'b0;
    @(posedge clk_in);
    #1;

    // Reset establishment cycle: registers are unknown before the first edge.
    apply(1'b1, 32'h0, 4'hF, 1'b1);
    advance();

    // rst irdy ov cd od oi ol
    vecs.push_back(mk(1, 32'h00000000, 4'hF, 1, 0, 0, 1, 8'h00, 2'd0, 0));
    vecs.push_back(mk(1, 32'h00000000, 4'hF, 1, 0, 0, 1, 8'h00, 2'd0, 0));
    vecs.push_back(mk(1, 32'h00000000, 4'hF, 1, 0, 0, 1, 8'h00, 2'd0, 0));
    vecs.push_back(mk(0, 32'h04030201, 4'hF, 1, 1, 0, 1, 8'h00, 2'd0, 0));
    vecs.push_back(mk(0, 32'hFFFFFFFF, 4'hF, 1, 0, 1, 1, 8'h01, 2'd0, 0));
    vecs.push_back(mk(0, 32'hEEEEEEEE, 4'hF, 1, 0, 1, 1, 8'h02, 2'd1, 0));
    vecs.push_back(mk(0, 32'h00000000, 4'hF, 1, 0, 1, 1, 8'h03, 2'd2, 0));
    vecs.push_back(mk(0, 32'h00000000, 4'h0, 1, 1, 1, 1, 8'h04, 2'd3, 1));
    vecs.push_back(mk(0, 32'h0D0C0B0A, 4'hA, 1, 1, 0, 0, 8'h00, 2'd0, 0));
    vecs.push_back(mk(0, 32'h00000000, 4'h0, 1, 0, 1, 1, 8'h0B, 2'd1, 0));
    vecs.push_back(mk(0, 32'h00000000, 4'h0, 1, 1, 1, 1, 8'h0D, 2'd3, 1));
    for (int k = 0; k < 5; k++) begin
      vecs.push_back(mk(0, 32'h5A5A5A5A, 4'h0, 1, 1, 0, 0, 8'h00, 2'd0, 0));
    end
    vecs.push_back(mk(0, 32'h00550000, 4'h4, 1, 1, 0, 0, 8'h00, 2'd0, 0));
    vecs.push_back(mk(0, 32'h00000000, 4'h0, 1, 1, 1, 1, 8'h55, 2'd2, 1));
    vecs.push_back(mk(0, 32'h00000000, 4'h0, 1, 1, 0, 0, 8'h00, 2'd0, 0));

    foreach (vecs[k]) begin
      apply(vecs[k].rst, vecs[k].d, vecs[k].v, vecs[k].r);
      chk("tbl_in_ready", 32'(in_ready), 32'(vecs[k].irdy));
      chk("tbl_out_valid", 32'(out_valid), 32'(vecs[k].ov));
      if (vecs[k].cd) begin
        chk("tbl_data_out", 32'(data_out), 32'(vecs[k].od));
        chk("tbl_out_idx", 32'(out_idx), 32'(vecs[k].oi));
        chk("tbl_out_last", 32'(out_last), 32'(vecs[k].ol));
      end
      advance();
    end

    // Back-to-back groups with a two-cycle stall on word 2.
    log_d.delete(); log_i.delete(); log_c.delete();
    for (int i = 0; i < 12; i++) begin
      logic [31:0] d;
      logic [3:0]  v;
      d = (i == 0) ? 32'h04030201 : (i <= 6) ? 32'h08070605 : 32'h0;
      v = (i <= 6) ? 4'hF : 4'h0;
      apply(1'b0, d, v, (i == 2 || i == 3) ? 1'b0 : 1'b1);
      check_model();
      advance();
    end
    chk("b2b_count", 32'(log_d.size()), 32'd8);
    for (int i = 0; i < 8 && i < log_d.size(); i++) begin
      chk("b2b_word", 32'(log_d[i]), 32'(i + 1));
    end
    if (log_c.size() == 8) chk("b2b_no_gap", 32'(log_c[4] - log_c[3]), 32'd1);

    // Reset in the middle of a group, then a fresh group.
    log_d.delete(); log_i.delete(); log_c.delete();
    for (int i = 0; i < 13; i++) begin
      logic [31:0] d;
      logic [3:0]  v;
      d = (i == 0) ? 32'h04030201 : (i == 7) ? 32'h09090909 : 32'h0;
      v = (i == 0 || i == 7) ? 4'hF : 4'h0;
      apply(i == 3, d, v, i != 3);
      check_model();
      if (i == 4) chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
      advance();
    end
    chk("rst_mid_count", 32'(log_d.size()), 32'd6);
    if (log_d.size() == 6) begin
      chk("rst_mid_w0", 32'(log_d[0]), 32'd1);
      chk("rst_mid_w1", 32'(log_d[1]), 32'd2);
      for (int i = 2; i < 6; i++) begin
        chk("rst_mid_new_word", 32'(log_d[i]), 32'd9);
        chk("rst_mid_new_idx", 32'(log_i[i]), 32'(i - 2));
      end
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic       rst;
      logic [3:0] v;
      rst = ($urandom_range(0, 49) == 0);
      v   = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
      apply(rst, $urandom, v, $urandom_range(0, 3) != 0);
      check_model();
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/word_serializer.md
Name: word_serializer

Overview:
- Parallel-to-serial converter: accepts a group of up to NUM words of WIDTH bits with a per-lane valid mask and emits the valid words one per clock on a single WIDTH-bit stream.
- Converts a NUM-lane word bus plus per-lane valid mask into one word per cycle.
- Feeds stream-consuming blocks; downstream backpressure via out_ready.

Parameters:
- WIDTH, 8, bits per word.
- NUM, 4, lanes per group (>=2); IDX_W = $clog2(NUM) derived locally.

Ports:
- clk_in  input  1  clock, rising edge.
- rst_in  input  1  synchronous reset, active-high.
- data_in  input  [NUM-1:0][WIDTH-1:0]  packed lane array, lane 0 = data_in[0].
- in_valid  input  [NUM-1:0]  per-lane valid mask; group offered when mask != 0.
- in_ready  output  1  block can accept a group this cycle.
- data_out  output  WIDTH  serialized word.
- out_idx  output  IDX_W  source lane index of data_out.
- out_valid  output  1  data_out/out_idx/out_last valid.
- out_last  output  1  current word is the last valid lane of its group.
- out_ready  input  1  downstream accepts the word when out_valid && out_ready.

Behaviour:
- Reset (rst_in high at an edge): state IDLE, data_out=0, out_idx=0, out_valid=0, out_last=0, held mask=0, held data=0. in_ready=0 while rst_in is high.
- Reset mid-group: pending words discarded, no further beats; outputs are reset values after that edge.
- Accept: load = in_ready && (in_valid != 0). On load, latch data_in and in_valid into holding registers. in_valid == 0 is never a load and is ignored.
- Emission order: ascending lane index; lanes with a clear mask bit are skipped with no bubble.
- Latency: first word registered on data_out with out_valid=1 at the edge after the load cycle (1 cycle).
- States:
  - IDLE: out_valid=0, in_ready=1; load -> SEND, present the lowest set lane.
  - SEND: out_valid=1. On a beat (out_ready=1), clear that lane's mask bit and present the next-lowest set lane. If the beat is on out_last: with a load that cycle -> stay SEND, present new group's first lane (back-to-back, no gap); without a load -> IDLE.
- in_ready = !rst_in && (state==IDLE || (out_valid && out_ready && out_last)). Combinational from registers and out_ready only, never from in_valid.
- Backpressure: with out_valid=1 and out_ready=0, data_out, out_idx, out_last and out_valid hold stable. No word is dropped or duplicated.
- out_last = 1 exactly when no set mask bit remains above out_idx. A single-lane group is one beat with out_last=1.
- data_in/in_valid changes while in_ready=0 are ignored; the held copy is used.
- Throughput: popcount(mask) cycles per group when out_ready stays high. Sustained 1 word/clock across groups.

Decomposition:
- Package word_serializer_pkg: state enum (IDLE, SEND), IDX_W helper function.
- Sub-module lowest_set_lane: combinational priority encoder, mask [NUM-1:0] -> idx [IDX_W-1:0], any, and "more above idx" flag for out_last. Instantiated once on the held mask with the current lane cleared.
- Top: holding registers, FSM, output registers.

Test Plan:
- Reset: hold rst_in 3 cycles with in_valid=4'b1111 -> in_ready=0, out_valid=0, data_out=0 throughout. in_ready=1 the cycle after rst_in falls.
- Full group, out_ready=1: data_in={4,3,2,1} (lane3..0), mask 4'b1111 -> data_out 1,2,3,4 on 4 consecutive cycles, out_idx 0..3, out_last only on 4. First word one cycle after load.
- Sparse mask: mask 4'b1010, data {8'hD,8'hC,8'hB,8'hA} -> exactly two beats: 8'hB (idx1), then 8'hD (idx3, out_last). in_ready=1 on the second beat.
- Back-to-back plus backpressure: groups {1,2,3,4} then {5,6,7,8} presented continuously; out_ready low for 2 cycles during word 2 -> word 2 held stable; stream 1..8 with no gap between 4 and 5; second group loaded on the word-4 beat cycle.
- Reset mid-group: full group loaded, rst_in pulsed after the second beat -> next cycle out_valid=0, no remaining words. A new group {9,9,9,9} serializes normally afterward.
- Zero mask / single lane: in_valid=0 for 5 cycles -> no output, state IDLE. Then mask 4'b0100, lane2=8'h55 -> one beat 8'h55, out_idx=2, out_last=1.
